mem_port_arbiter: RTL and testbench

- Shares one simple dual-port `mem` instance (1 write port, 1 registered read port) between NREQ requesters.
- Read and write ports are arbitrated independently, each with its own round-robin pointer.
- Read data is returned with a per-requester valid strobe one cycle after grant, aligned to the `mem` read latency.
- Sits between the elimination datapath units (pivot search, row update, load/store) and the matrix storage RAM.

---
 rtl/gausselim_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gausselim_pkg.sv
// Shared constants and helpers for the elimination datapath blocks.
package gausselim_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 64;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import gausselim_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]               req,
  input  logic [clog2_min1(N)-1:0]   ptr,
  output logic [N-1:0]               gnt,
  output logic [clog2_min1(N)-1:0]   idx,
  output logic                       any
);

  localparam int unsigned PW = clog2_min1(N);

  logic [31:0]   k32;
  logic [PW-1:0] kk;

  // Scan from ptr; idx falls back to ptr when nothing is requested.
  always_comb begin
    gnt = '0;
    idx = ptr;
    any = 1'b0;
    k32 = '0;
    kk  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      k32 = 32'(ptr) + off;
      if (k32 >= N) k32 = k32 - N;
      kk = PW'(k32);
      if (!any && req[kk]) begin
        any     = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one dual-port RAM between NREQ requesters with independent
// round-robin read and write arbitration and a read-after-write hazard hold.
module mem_port_arbiter
  import gausselim_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       wr_req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       wr_gnt,
  input  logic [NREQ-1:0]       rd_req,
  input  logic [NREQ*AW-1:0]    rd_addr,
  output logic [NREQ-1:0]       rd_gnt,
  output logic [NREQ-1:0]       rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic [WIDTH-1:0]      mem_data,
  output logic [AW-1:0]         mem_wraddress,
  output logic                  mem_wren,
  output logic [AW-1:0]         mem_rdaddress,
  output logic                  mem_rden,
  input  logic [WIDTH-1:0]      mem_q
);

  localparam int unsigned PW = clog2_min1(NREQ);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NREQ-1:0] rd_valid_q;

  logic [NREQ-1:0] wr_pick_gnt, rd_pick_gnt;
  logic [PW-1:0]   wr_idx, rd_idx;
  logic            wr_any, rd_any;
  logic [AW-1:0]   rd_sel_addr;
  logic            hazard;

  rr_pick #(.N(NREQ)) u_wr_pick (
    .req (wr_req),
    .ptr (wr_ptr_q),
    .gnt (wr_pick_gnt),
    .idx (wr_idx),
    .any (wr_any)
  );

  rr_pick #(.N(NREQ)) u_rd_pick (
    .req (rd_req),
    .ptr (rd_ptr_q),
    .gnt (rd_pick_gnt),
    .idx (rd_idx),
    .any (rd_any)
  );

  // Port muxing, hazard hold and next-pointer computation.
  always_comb begin
    mem_wraddress = wr_addr[32'(wr_idx)*AW +: AW];
    mem_data      = wr_data[32'(wr_idx)*WIDTH +: WIDTH];
    rd_sel_addr   = rd_addr[32'(rd_idx)*AW +: AW];
    wr_gnt        = wr_pick_gnt;
    mem_wren      = wr_any;
    hazard        = wr_any && rd_any && (mem_wraddress == rd_sel_addr);
    rd_gnt        = hazard ? '0 : rd_pick_gnt;
    mem_rden      = rd_any && !hazard;
    mem_rdaddress = rd_sel_addr;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (wr_any) begin
      wr_ptr_d = (wr_idx == PW'(NREQ-1)) ? '0 : wr_idx + PW'(1);
    end
    if (mem_rden) begin
      rd_ptr_d = (rd_idx == PW'(NREQ-1)) ? '0 : rd_idx + PW'(1);
    end
  end

  // Pointer and read-valid registers; valid lines up with the RAM's registered q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_gnt;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM stand-in, round-robin reference model and directed tests.
module tb_mem_port_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic                  clock;
  logic                  reset_n;
  logic [NREQ-1:0]       wr_req, rd_req;
  logic [NREQ*AW-1:0]    wr_addr, rd_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       wr_gnt, rd_gnt, rd_valid;
  logic [WIDTH-1:0]      rd_data, mem_data, mem_q;
  logic [AW-1:0]         mem_wraddress, mem_rdaddress;
  logic                  mem_wren, mem_rden;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_data(mem_data), .mem_wraddress(mem_wraddress),
    .mem_wren(mem_wren), .mem_rdaddress(mem_rdaddress), .mem_rden(mem_rden),
    .mem_q(mem_q)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Stand-in for the RAM: one write port, registered read port.
  logic [WIDTH-1:0] mem_arr [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;
    mem_q = '0;
  end
  always @(posedge clock) begin
    if (mem_wren) mem_arr[mem_wraddress] <= mem_data;
    if (mem_rden) mem_q <= mem_arr[mem_rdaddress];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [NREQ*AW-1:0] v, input int i);
    return v[i*AW +: AW];
  endfunction

  function automatic logic [WIDTH-1:0] data_of(input logic [NREQ*WIDTH-1:0] v, input int i);
    return v[i*WIDTH +: WIDTH];
  endfunction

  // Reference model: pointers as integers, shadow memory contents, expected read return.
  int               wp, rp;
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [NREQ-1:0]  exp_valid;
  logic [WIDTH-1:0] exp_data;

  initial for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp = 0;
      rp = 0;
      exp_valid = '0;
      exp_data  = '0;
    end else begin
      int  k, j, idx;
      bit  wfound, rfound, rgrant;
      logic [NREQ-1:0]  exp_wg, exp_rg;
      logic [WIDTH-1:0] rd_val;
      wfound = 0; rfound = 0; k = 0; j = 0;
      for (int off = 0; off < NREQ; off++) begin
        idx = (wp + off) % NREQ;
        if (!wfound && wr_req[idx]) begin wfound = 1; k = idx; end
        idx = (rp + off) % NREQ;
        if (!rfound && rd_req[idx]) begin rfound = 1; j = idx; end
      end
      rgrant = rfound && !(wfound && addr_of(wr_addr, k) == addr_of(rd_addr, j));
      exp_wg = wfound ? NREQ'(1 << k) : '0;
      exp_rg = rgrant ? NREQ'(1 << j) : '0;
      check("model_wr_gnt", 32'(wr_gnt), 32'(exp_wg));
      check("model_mem_wren", 32'(mem_wren), 32'(wfound));
      check("model_wr_addr", 32'(mem_wraddress), 32'(addr_of(wr_addr, wfound ? k : wp)));
      if (wfound) check("model_wr_data", 32'(mem_data), 32'(data_of(wr_data, k)));
      check("model_rd_gnt", 32'(rd_gnt), 32'(exp_rg));
      check("model_mem_rden", 32'(mem_rden), 32'(rgrant));
      if (rgrant) check("model_rd_addr", 32'(mem_rdaddress), 32'(addr_of(rd_addr, j)));
      check("model_rd_valid", 32'(rd_valid), 32'(exp_valid));
      if (exp_valid != '0) check("model_rd_data", 32'(rd_data), 32'(exp_data));
      // Advance model to the state after the coming rising edge.
      rd_val = rgrant ? shadow[addr_of(rd_addr, j)] : '0;
      if (wfound) begin
        shadow[addr_of(wr_addr, k)] = data_of(wr_data, k);
        wp = (k + 1) % NREQ;
      end
      if (rgrant) rp = (j + 1) % NREQ;
      exp_valid = exp_rg;
      exp_data  = rd_val;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_all();
    wr_req = '0; rd_req = '0;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_req[i] = 1'b1;
    wr_addr[i*AW +: AW] = a;
    wr_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_req[i] = 1'b1;
    rd_addr[i*AW +: AW] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;

    // Reset with all requests asserted.
    for (int i = 0; i < NREQ; i++) begin
      set_wr(i, AW'(10 + i), WIDTH'(8'h10 + i));
      set_rd(i, AW'(20 + i));
    end
    sample();
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    tick();
    reset_n = 1'b1;
    sample();
    check("rel_wr_gnt0", 32'(wr_gnt), 32'h1);
    check("rel_rd_gnt0", 32'(rd_gnt), 32'h1);
    sample();
    check("rel_wr_gnt1", 32'(wr_gnt), 32'h2);
    check("rel_rd_gnt1", 32'(rd_gnt), 32'h2);
    tick();
    clear_all();

    // Write 0xA5 to addr 3 from requester 2, then read it back from requester 0.
    tick();
    set_wr(2, 6'd3, 8'hA5);
    sample();
    check("wr_a5_gnt", 32'(wr_gnt), 32'h4);
    tick();
    clear_all();
    set_rd(0, 6'd3);
    sample();
    check("rd_a5_gnt", 32'(rd_gnt), 32'h1);
    tick();
    clear_all();
    sample();
    check("rd_a5_valid", 32'(rd_valid), 32'h1);
    check("rd_a5_data", 32'(rd_data), 32'hA5);

    // Same-address write and read: read held one cycle, then sees the new data.
    tick();
    set_wr(1, 6'd5, 8'h3C);
    set_rd(0, 6'd5);
    sample();
    check("haz_wr_gnt", 32'(wr_gnt), 32'h2);
    check("haz_rd_held", 32'(rd_gnt), 32'h0);
    check("haz_rden", 32'(mem_rden), 32'h0);
    tick();
    wr_req = '0;
    sample();
    check("haz_rd_gnt", 32'(rd_gnt), 32'h1);
    tick();
    clear_all();
    sample();
    check("haz_rd_valid", 32'(rd_valid), 32'h1);
    check("haz_rd_data", 32'(rd_data), 32'h3C);

    // Short reset pulse between edges, then all four read continuously.
    tick();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_rd(i, AW'(40 + i));
    for (int c = 0; c < 8; c++) begin
      sample();
      check("rr_rd_gnt", 32'(rd_gnt), 32'(1 << (c % 4)));
      if (c > 0) check("rr_rd_valid", 32'(rd_valid), 32'(1 << ((c - 1) % 4)));
      tick();
    end
    clear_all();

    // Requester 3 alone reads and writes different addresses together.
    set_wr(3, 6'd51, 8'h77);
    set_rd(3, 6'd50);
    sample();
    check("r3_wr_gnt", 32'(wr_gnt), 32'h8);
    check("r3_rd_gnt", 32'(rd_gnt), 32'h8);
    tick();
    clear_all();
    sample();
    check("r3_rd_valid", 32'(rd_valid), 32'h8);

    // Async reset while requester 2 is being served.
    tick();
    set_rd(2, 6'd30);
    sample();
    check("ar_rd_gnt", 32'(rd_gnt), 32'h4);
    tick();
    check("ar_valid_pre", 32'(rd_valid), 32'h4);
    check("ar_rd_gnt2", 32'(rd_gnt), 32'h4);
    reset_n = 1'b0;
    #1;
    check("ar_valid_cleared", 32'(rd_valid), 32'h0);
    clear_all();
    set_rd(1, 6'd61);
    set_rd(3, 6'd63);
    set_wr(1, 6'd60, 8'h11);
    set_wr(2, 6'd62, 8'h22);
    tick();
    tick();
    reset_n = 1'b1;
    sample();
    check("ar_first_rd", 32'(rd_gnt), 32'h2);
    check("ar_first_wr", 32'(wr_gnt), 32'h2);
    tick();
    clear_all();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
